// File: rtl/stats_vector_serializer.sv
// Statistics vector serializer: captures each channel's vector on its valid edge and streams
// {2'b01, channel id, vector} frames MSB first on a single wire, served round-robin.
module stats_vector_serializer #(
   parameter int NUM_CH = 2,
   parameter int VEC_W  = 32
) (
   input  logic                    coreclk,
   input  logic                    reset,
   input  logic [NUM_CH*VEC_W-1:0] stats_vector,
   input  logic [NUM_CH-1:0]       stats_valid,
   output logic                    serial_out,
   output logic                    busy,
   output logic [NUM_CH-1:0]       drop_pulse,
   output logic [15:0]             drop_count
);

   localparam int CH_ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
   localparam int L       = 2 + CH_ID_W + VEC_W;
   localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W   = $clog2(L);

   typedef enum logic [0:0] {IDLE, SHIFT} state_t;

   state_t             state_q;
   logic [NUM_CH-1:0]  valid_q;
   logic [NUM_CH-1:0]  pending_q;
   logic [NUM_CH-1:0]  pending_d;
   logic [NUM_CH-1:0]  capture;
   logic [NUM_CH-1:0]  drop_d;
   logic [NUM_CH-1:0]  drop_pulse_q;
   logic [NUM_CH-1:0]  events;
   logic [NUM_CH-1:0]  load_sel;
   logic [VEC_W-1:0]   hold_q [NUM_CH];
   logic [PTR_W-1:0]   rr_q;
   logic [PTR_W-1:0]   grant;
   logic               grant_found;
   logic               load;
   logic [VEC_W-1:0]   grant_vec;
   logic [L-1:0]       frame;
   logic [L-1:0]       shift_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               serial_q;
   logic               busy_q;
   logic [15:0]        drop_count_q;
   logic [15:0]        drop_count_d;
   logic [4:0]         drop_num;
   logic [16:0]        drop_sum;

   assign events = stats_valid & ~valid_q;
   assign load   = (state_q == IDLE) && grant_found;

   // Round-robin search starts at the channel after the one served last.
   always_comb begin
      grant_found = 1'b0;
      grant       = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (!grant_found && pending_q[c] && (((int'(rr_q) + k) % NUM_CH) == c)) begin
               grant_found = 1'b1;
               grant       = PTR_W'(c);
            end
         end
      end
   end

   always_comb begin
      grant_vec = '0;
      load_sel  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (int'(grant) == c) begin
            grant_vec   = hold_q[c];
            load_sel[c] = load;
         end
      end
   end

   assign frame = (L'(2'b01) << (CH_ID_W + VEC_W)) | (L'(grant) << VEC_W) | L'(grant_vec);

   // A channel being moved into the shifter this cycle frees its buffer, so a new edge is kept.
   always_comb begin
      pending_d = pending_q;
      capture   = '0;
      drop_d    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (load_sel[c]) begin
            pending_d[c] = 1'b0;
         end
         if (events[c]) begin
            if (!pending_q[c] || load_sel[c]) begin
               capture[c]   = 1'b1;
               pending_d[c] = 1'b1;
            end else begin
               drop_d[c] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      drop_num = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         drop_num = drop_num + 5'(drop_d[c]);
      end
      drop_sum     = {1'b0, drop_count_q} + 17'(drop_num);
      drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge coreclk) begin
      if (reset) begin
         valid_q      <= '0;
         pending_q    <= '0;
         drop_pulse_q <= '0;
         drop_count_q <= '0;
      end else begin
         valid_q      <= stats_valid;
         pending_q    <= pending_d;
         drop_pulse_q <= drop_d;
         drop_count_q <= drop_count_d;
      end
   end

   always_ff @(posedge coreclk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (capture[c]) begin
            hold_q[c] <= stats_vector[c*VEC_W +: VEC_W];
         end
      end
   end

   // The marker bit goes out in the first busy cycle, so the shifter is loaded pre-shifted.
   always_ff @(posedge coreclk) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_q     <= PTR_W'(NUM_CH - 1);
         shift_q  <= '0;
         cnt_q    <= '0;
         serial_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               serial_q <= 1'b0;
               busy_q   <= 1'b0;
               if (load) begin
                  shift_q  <= frame << 1;
                  serial_q <= frame[L-1];
                  busy_q   <= 1'b1;
                  cnt_q    <= CNT_W'(L - 1);
                  rr_q     <= grant;
                  state_q  <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt_q == '0) begin
                  serial_q <= 1'b0;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end else begin
                  serial_q <= shift_q[L-1];
                  shift_q  <= shift_q << 1;
                  cnt_q    <= cnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign serial_out = serial_q;
   assign busy       = busy_q;
   assign drop_pulse = drop_pulse_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_stats_vector_serializer.sv
// Bench for stats_vector_serializer: a frame scoreboard fed by the stimulus, table rows of
// single/simultaneous captures, and hand sequences for drops, saturation, held valid and reset.
`timescale 1ns/1ps
module tb_stats_vector_serializer;

   localparam int L  = 35;
   localparam int L1 = 28;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] statsVector;
   logic [1:0]  statsValid;
   logic        serialOut, busy;
   logic [1:0]  dropPulse;
   logic [15:0] dropCount;
   logic [25:0] vector1;
   logic        valid1, serial1, busy1, dropPulse1;
   logic [15:0] dropCount1;
   logic [31:0] vectorS;
   logic [7:0]  validS, dropPulseS;
   logic        serialS, busyS;
   logic [15:0] dropCountS;

   int total = 0, bad = 0, cyc = 0;
   logic [34:0] expQ[$];
   logic [27:0] expQ1[$];
   logic [34:0] shiftIn = '0;
   logic [27:0] shiftIn1 = '0;
   int bitCnt = 0, bitCnt1 = 0, framesSeen = 0, frames1 = 0;
   int lastStart = -1, prevStart = -1;
   bit gapPending = 0;
   int pulseCnt [2] = '{0, 0};
   int pulseCntS = 0;

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] vec0;
      logic [31:0] vec1;
      int          nExp;
      logic [34:0] exp0;
      logic [34:0] exp1;
   } vecRow_t;
   vecRow_t rows [5];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   stats_vector_serializer #(.NUM_CH(2), .VEC_W(32)) dut (
      .coreclk(clk), .reset(reset), .stats_vector(statsVector), .stats_valid(statsValid),
      .serial_out(serialOut), .busy(busy), .drop_pulse(dropPulse), .drop_count(dropCount));

   stats_vector_serializer #(.NUM_CH(1), .VEC_W(26)) dut1 (
      .coreclk(clk), .reset(reset), .stats_vector(vector1), .stats_valid(valid1),
      .serial_out(serial1), .busy(busy1), .drop_pulse(dropPulse1), .drop_count(dropCount1));

   stats_vector_serializer #(.NUM_CH(8), .VEC_W(4)) dutS (
      .coreclk(clk), .reset(reset), .stats_vector(vectorS), .stats_valid(validS),
      .serial_out(serialS), .busy(busyS), .drop_pulse(dropPulseS), .drop_count(dropCountS));

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] v, input logic [31:0] v0, input logic [31:0] v1);
      statsVector = {v1, v0};
      statsValid  = v;
      step();
      statsValid  = '0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      pulseCnt[0] = 0;
      pulseCnt[1] = 0;
      pulseCntS = 0;
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while ((expQ.size() != 0 || busy || bitCnt != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checkOutput(name, expQ.size(), 0);
   endtask

   task automatic waitDrain1(input string name);
      int n = 0;
      while ((expQ1.size() != 0 || busy1 || bitCnt1 != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checkOutput(name, expQ1.size(), 0);
   endtask

   // Frame collector: assembles busy-qualified bits and compares each frame with the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         bitCnt = 0;
         bitCnt1 = 0;
         gapPending = 0;
      end else begin
         for (int i = 0; i < 2; i++) if (dropPulse[i]) pulseCnt[i]++;
         for (int i = 0; i < 8; i++) if (dropPulseS[i]) pulseCntS++;
         if (gapPending) begin
            checkOutput("frame gap busy", busy, 0);
            gapPending = 0;
         end
         if (busy) begin
            if (bitCnt == 0) begin
               prevStart = lastStart;
               lastStart = cyc;
            end
            shiftIn = {shiftIn[33:0], serialOut};
            bitCnt++;
            if (bitCnt == L) begin
               bitCnt = 0;
               gapPending = 1;
               framesSeen++;
               if (expQ.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected frame: got %h expected none", shiftIn);
               end else begin
                  checkOutput("frame", shiftIn, expQ.pop_front());
               end
            end
         end else begin
            if (bitCnt != 0) begin
               total++;
               bad++;
               $display("[TB] FAIL truncated frame: got %0d bits expected %0d", bitCnt, L);
            end
            bitCnt = 0;
            checkOutput("idle serial", serialOut, 0);
         end
         if (busy1) begin
            shiftIn1 = {shiftIn1[26:0], serial1};
            bitCnt1++;
            if (bitCnt1 == L1) begin
               bitCnt1 = 0;
               frames1++;
               if (expQ1.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected frame1: got %h expected none", shiftIn1);
               end else begin
                  checkOutput("frame1", shiftIn1, expQ1.pop_front());
               end
            end
         end else begin
            bitCnt1 = 0;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int satIter;
      int pulsesAtSat;
      int framesBefore;

      rows[0] = '{2'b01, 32'h00000000, 32'h00000000, 1, {2'b01, 1'b0, 32'h00000000}, 35'h0};
      rows[1] = '{2'b10, 32'h00000000, 32'hFFFFFFFF, 1, {2'b01, 1'b1, 32'hFFFFFFFF}, 35'h0};
      rows[2] = '{2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, {2'b01, 1'b0, 32'hA5A5A5A5},
                  {2'b01, 1'b1, 32'h5A5A5A5A}};
      rows[3] = '{2'b01, 32'h80000001, 32'h00000000, 1, {2'b01, 1'b0, 32'h80000001}, 35'h0};
      rows[4] = '{2'b11, 32'h12345678, 32'hDEADBEEF, 2, {2'b01, 1'b0, 32'h12345678},
                  {2'b01, 1'b1, 32'hDEADBEEF}};

      reset = 1'b1;
      statsValid = '0;
      statsVector = '0;
      valid1 = 1'b1;
      vector1 = 26'h2ABCDEF;
      validS = '0;
      vectorS = 32'h76543210;
      expQ1.push_back({2'b01, 26'h2ABCDEF});
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset serial", serialOut, 0);
      checkOutput("reset drop_pulse", dropPulse, 0);
      checkOutput("reset drop_count", dropCount, 0);
      checkOutput("reset busy1", busy1, 0);
      checkOutput("reset serial1", serial1, 0);
      checkOutput("reset busyS", busyS, 0);
      checkOutput("reset serialS", serialS, 0);
      checkOutput("reset drop_countS", dropCountS, 0);

      // Valid held high across reset release and for 100 cycles: exactly one 28-bit frame.
      repeat (100) step();
      valid1 = 1'b0;
      waitDrain1("held valid drain");
      checkOutput("held valid frames", frames1, 1);
      checkOutput("held valid drops", dropCount1, 0);
      checkOutput("held valid pulse", dropPulse1, 0);

      // Single frame with cycle-exact latency.
      expQ.push_back({2'b01, 1'b0, 32'h89ABCDEF});
      applyStimulus(2'b01, 32'h89ABCDEF, 32'h0);
      @(negedge clk);
      checkOutput("single t+1 busy", busy, 0);
      @(negedge clk);
      checkOutput("single t+2 busy", busy, 1);
      checkOutput("single t+2 marker0", serialOut, 0);
      @(negedge clk);
      checkOutput("single t+3 marker1", serialOut, 1);
      repeat (33) @(negedge clk);
      checkOutput("single t+36 busy", busy, 1);
      checkOutput("single t+36 last bit", serialOut, 1);
      @(negedge clk);
      checkOutput("single t+37 busy", busy, 0);
      checkOutput("single t+37 serial", serialOut, 0);
      waitDrain("single drain");

      // Simultaneous edges: ch0 first, one idle cycle, then ch1.
      doReset();
      expQ.push_back({2'b01, 1'b0, 32'h00000001});
      expQ.push_back({2'b01, 1'b1, 32'h00000002});
      applyStimulus(2'b11, 32'h1, 32'h2);
      waitDrain("simultaneous drain");
      checkOutput("simultaneous spacing", lastStart - prevStart, L + 1);
      checkOutput("simultaneous drops", dropCount, 0);
      checkOutput("simultaneous pulses", pulseCnt[0] + pulseCnt[1], 0);

      for (int r = 0; r < 5; r++) begin
         doReset();
         expQ.push_back(rows[r].exp0);
         if (rows[r].nExp == 2) expQ.push_back(rows[r].exp1);
         applyStimulus(rows[r].valid, rows[r].vec0, rows[r].vec1);
         waitDrain($sformatf("row%0d drain", r));
         checkOutput($sformatf("row%0d drops", r), dropCount, 0);
      end

      // Edge arriving in the very cycle its channel is loaded is kept, not dropped.
      doReset();
      expQ.push_back({2'b01, 1'b1, 32'hA1A1A1A1});
      expQ.push_back({2'b01, 1'b0, 32'hB2B2B2B2});
      expQ.push_back({2'b01, 1'b0, 32'hC3C3C3C3});
      applyStimulus(2'b10, 32'h0, 32'hA1A1A1A1);
      step();
      step();
      applyStimulus(2'b01, 32'hB2B2B2B2, 32'hA1A1A1A1);
      repeat (33) step();
      applyStimulus(2'b01, 32'hC3C3C3C3, 32'hA1A1A1A1);
      waitDrain("load-cycle accept drain");
      checkOutput("load-cycle accept drops", dropCount, 0);

      // Three ch1 edges while ch0 shifts: first kept, the next two dropped.
      doReset();
      expQ.push_back({2'b01, 1'b0, 32'hCAFEF00D});
      expQ.push_back({2'b01, 1'b1, 32'h11111111});
      applyStimulus(2'b01, 32'hCAFEF00D, 32'h0);
      step();
      step();
      applyStimulus(2'b10, 32'h0, 32'h11111111);
      step();
      step();
      applyStimulus(2'b10, 32'h0, 32'h22222222);
      @(negedge clk);
      checkOutput("drop1 pulse", dropPulse, 2'b10);
      checkOutput("drop1 count", dropCount, 1);
      @(negedge clk);
      checkOutput("drop1 pulse end", dropPulse, 2'b00);
      @(posedge clk);
      #1;
      applyStimulus(2'b10, 32'h0, 32'h33333333);
      @(negedge clk);
      checkOutput("drop2 pulse", dropPulse, 2'b10);
      checkOutput("drop2 count", dropCount, 2);
      waitDrain("drop drain");
      checkOutput("drop pulses ch1", pulseCnt[1], 2);
      checkOutput("drop pulses ch0", pulseCnt[0], 0);
      checkOutput("drop final count", dropCount, 2);

      // Saturation on the 8-channel instance: every channel toggles every other cycle.
      doReset();
      satIter = 0;
      while (pulseCntS < 32'h10005 && satIter < 40000) begin
         validS = 8'hFF;
         step();
         validS = 8'h00;
         step();
         satIter++;
         if (satIter == 200) begin
            @(negedge clk);
            #1;
            checkOutput("sat count tracks pulses", dropCountS, pulseCntS);
         end
      end
      @(negedge clk);
      #1;
      checkOutput("sat reached", pulseCntS >= 32'h10005, 1);
      checkOutput("sat count", dropCountS, 16'hFFFF);
      pulsesAtSat = pulseCntS;
      repeat (20) begin
         validS = 8'hFF;
         step();
         validS = 8'h00;
         step();
      end
      @(negedge clk);
      #1;
      checkOutput("sat pulses continue", pulseCntS > pulsesAtSat, 1);
      checkOutput("sat count held", dropCountS, 16'hFFFF);

      // Reset at frame bit 10 aborts the frame and discards the pending ch1 entry.
      doReset();
      applyStimulus(2'b01, 32'h0F0F0F0F, 32'h0);
      applyStimulus(2'b10, 32'h0F0F0F0F, 32'hBAD0BAD0);
      repeat (9) step();
      checkOutput("abort busy before reset", busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort busy", busy, 0);
      checkOutput("abort serial", serialOut, 0);
      checkOutput("abort drop_count", dropCount, 0);
      checkOutput("abort drop_pulse", dropPulse, 0);
      framesBefore = framesSeen;
      repeat (60) step();
      checkOutput("abort no stale frame", framesSeen, framesBefore);
      expQ.push_back({2'b01, 1'b0, 32'h76543210});
      applyStimulus(2'b01, 32'h76543210, 32'h0);
      waitDrain("after abort drain");
      checkOutput("after abort frames", framesSeen, framesBefore + 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
